stub_router: RTL and testbench

STUB_ROUTER -- requirements
Module: stub_router

---
 rtl/stub_router_pkg.sv | 25 ++
 rtl/stub_router_if.sv | 25 ++
 rtl/stub_router_bounds.sv | 46 ++++
 rtl/stub_router.sv | 162 ++++++++++++++++
 tb/tb_stub_router.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/stub_router_pkg.sv
// Shared types and framing constants for the stub router: FSM states,
// header/trailer markers and the BX field position inside framing words.
package stub_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_CNTS  = 3'd2,
        ST_STUBS = 3'd3,
        ST_TRAIL = 3'd4
    } state_e;

    localparam logic [2:0] FRAME_TAG = 3'b111;
    localparam int MARK_W = 25;
    localparam logic [MARK_W-1:0] HDR_MARK = {MARK_W{1'b1}};
    localparam logic [MARK_W-1:0] TRL_MARK = {MARK_W{1'b0}};
    localparam int BX_LSB = 25;
    localparam int BX_MSB = 32;

    // The next bunch crossing wraps naturally at 8 bits
    function automatic logic [7:0] bx_incr(input logic [7:0] bx);
        return bx + 8'd1;
    endfunction

endpackage

// File: rtl/stub_router_if.sv
// Stream-in / channel-strobe-out bundle of the stub router.
// The master side drives the event stream, the slave side is the router.
interface stub_router_if #(
    parameter int N_OUT  = 6,
    parameter int DATA_W = 36
) ();
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [N_OUT-1:0]  out_wr_en;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        bx_next;
    logic              done;
    logic [2:0]        err;

    modport master (
        output start, in_valid, in_data,
        input  out_wr_en, out_data, bx_next, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output out_wr_en, out_data, bx_next, done, err
    );
endinterface

// File: rtl/stub_router_bounds.sv
// Cumulative channel boundaries: bound[i] is the sum of counts 0..i,
// captured when the count word is accepted and held for the event.
module stub_router_bounds #(
    parameter int N_OUT = 6,
    parameter int CNT_W = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [N_OUT*CNT_W-1:0]       count_word,
    output logic [N_OUT-1:0][CNT_W+2:0]  bound,
    output logic                         ovf
);
    localparam int BW        = CNT_W + 3;
    localparam int OVF_LIMIT = (2 ** CNT_W) * N_OUT - 1;

    logic [N_OUT-1:0][BW-1:0] sum_s;
    logic [BW-1:0]            acc_s;
    logic [N_OUT-1:0][BW-1:0] bound_r;

    // Running prefix sum, channel 0 taken from the most significant field
    always_comb begin
        acc_s = '0;
        sum_s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            acc_s    = acc_s + BW'(count_word[(N_OUT-i)*CNT_W-1 -: CNT_W]);
            sum_s[i] = acc_s;
        end
    end

    assign ovf = int'(sum_s[N_OUT-1]) > OVF_LIMIT;

    // Boundary register, loaded only on the count beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bound_r <= '0;
        end else if (load) begin
            bound_r <= sum_s;
        end else begin
            bound_r <= bound_r;
        end
    end

    assign bound = bound_r;

endmodule

// File: rtl/stub_router.sv
// Event-framed stub demultiplexer: header, packed per-channel counts,
// stub words routed to channels by cumulative count, trailer with BX.
module stub_router
    import stub_router_pkg::*;
#(
    parameter int N_OUT  = 6,
    parameter int DATA_W = 36,
    parameter int CNT_W  = 6
) (
    input  logic          clk,
    input  logic          reset,
    stub_router_if.slave  bus
);
    localparam int BW = CNT_W + 3;

    state_e                   state_r, state_s;
    logic [BW-1:0]            stub_cnt_r;
    logic [N_OUT-1:0][BW-1:0] bound_s;
    logic                     ovf_s;
    logic                     is_hdr_s, is_trl_s, any_cnt_s, last_stub_s, hit_s;
    logic                     cnt_load_s, stub_acc_s, trl_ok_s, trl_bad_s, abort_s;
    logic [N_OUT-1:0]         route_s;
    logic [N_OUT-1:0]         wr_en_r;
    logic [DATA_W-1:0]        data_r;
    logic [7:0]               bx_r;
    logic                     done_r;
    logic [2:0]               err_r;

    assign is_hdr_s  = (bus.in_data[DATA_W-1 -: 3] == FRAME_TAG) && (bus.in_data[MARK_W-1:0] == HDR_MARK);
    assign is_trl_s  = (bus.in_data[DATA_W-1 -: 3] == FRAME_TAG) && (bus.in_data[MARK_W-1:0] == TRL_MARK);
    assign any_cnt_s = |bus.in_data[DATA_W-1 -: N_OUT*CNT_W];
    assign last_stub_s = (stub_cnt_r == (bound_s[N_OUT-1] - BW'(1'b1)));

    stub_router_bounds #(.N_OUT(N_OUT), .CNT_W(CNT_W)) u_bounds (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load_s),
        .count_word (bus.in_data[DATA_W-1 -: N_OUT*CNT_W]),
        .bound      (bound_s),
        .ovf        (ovf_s)
    );

    // Lowest channel whose boundary lies above the stub index; empty channels never match
    always_comb begin
        route_s = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (!hit_s && (stub_cnt_r < bound_s[i])) begin
                route_s[i] = 1'b1;
                hit_s      = 1'b1;
            end else begin
                route_s[i] = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-beat actions; a start past HEAD aborts the event
    always_comb begin
        state_s    = state_r;
        cnt_load_s = 1'b0;
        stub_acc_s = 1'b0;
        trl_ok_s   = 1'b0;
        trl_bad_s  = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_HEAD;
                else           state_s = ST_IDLE;
            end
            ST_HEAD: begin
                if (bus.in_valid && is_hdr_s) state_s = ST_CNTS;
                else                          state_s = ST_HEAD;
            end
            ST_CNTS: begin
                if (bus.start) begin
                    abort_s = 1'b1;
                    state_s = ST_HEAD;
                end else if (bus.in_valid) begin
                    cnt_load_s = 1'b1;
                    state_s    = any_cnt_s ? ST_STUBS : ST_TRAIL;
                end else begin
                    state_s = ST_CNTS;
                end
            end
            ST_STUBS: begin
                if (bus.start) begin
                    abort_s = 1'b1;
                    state_s = ST_HEAD;
                end else if (bus.in_valid) begin
                    stub_acc_s = 1'b1;
                    state_s    = last_stub_s ? ST_TRAIL : ST_STUBS;
                end else begin
                    state_s = ST_STUBS;
                end
            end
            ST_TRAIL: begin
                if (bus.start) begin
                    abort_s = 1'b1;
                    state_s = ST_HEAD;
                end else if (bus.in_valid && is_trl_s) begin
                    trl_ok_s = 1'b1;
                    state_s  = ST_HEAD;
                end else if (bus.in_valid) begin
                    trl_bad_s = 1'b1;
                    state_s   = ST_TRAIL;
                end else begin
                    state_s = ST_TRAIL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, saturating stub counter and per-event error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_cnt_r <= '0;
            wr_en_r    <= '0;
            data_r     <= '0;
            bx_r       <= 8'd0;
            done_r     <= 1'b0;
            err_r      <= 3'b000;
        end else begin
            wr_en_r <= stub_acc_s ? route_s : '0;
            data_r  <= stub_acc_s ? bus.in_data : data_r;
            if (abort_s || cnt_load_s || (stub_acc_s && last_stub_s)) begin
                stub_cnt_r <= '0;
            end else if (stub_acc_s && (stub_cnt_r != {BW{1'b1}})) begin
                stub_cnt_r <= stub_cnt_r + BW'(1'b1);
            end else begin
                stub_cnt_r <= stub_cnt_r;
            end
            bx_r   <= trl_ok_s ? bx_incr(bus.in_data[BX_MSB:BX_LSB]) : bx_r;
            done_r <= trl_ok_s;
            if (bus.start) begin
                err_r <= {abort_s, 1'b0, 1'b0};
            end else if (done_r) begin
                err_r <= 3'b000;
            end else begin
                err_r <= err_r | {1'b0, trl_bad_s, cnt_load_s & ovf_s};
            end
        end
    end

    assign bus.out_wr_en = wr_en_r;
    assign bus.out_data  = data_r;
    assign bus.bx_next   = bx_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_stub_router.sv
// Self-checking bench for stub_router: table of events plus hand-written
// corner sequences; expected strobes go through a one-cycle scoreboard queue.
module tb_stub_router;

    typedef struct {
        int          ch;
        logic [35:0] data;
    } exp_t;

    typedef struct {
        logic [0:5][5:0] c;
        logic [7:0]      bx;
        logic [7:0]      exp_bx;
    } vec_t;

    localparam logic [35:0] HDR = {3'b111, 8'h00, 25'h1FFFFFF};

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t vecs[5];

    stub_router_if #(.N_OUT(6), .DATA_W(36)) bus ();

    stub_router #(.N_OUT(6), .DATA_W(36), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [35:0] trailer(input logic [7:0] bx);
        return {3'b111, bx, 25'h0};
    endfunction

    function automatic logic [35:0] rnd36();
        logic [35:0] d;
        d = {4'($urandom), 32'($urandom)};
        return d | 36'h1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted stub must strobe exactly at the next sample
    task automatic monitor();
        exp_t it;
        logic [5:0] oh;
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            oh = 6'b000001 << it.ch;
            check("strobe", 64'(bus.out_wr_en), 64'(oh));
            check("out_data", 64'(bus.out_data), 64'(it.data));
        end else if (bus.out_wr_en != 6'b000000) begin
            check("unexpected_strobe", 64'(bus.out_wr_en), 64'd0);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge
    task automatic cyc(input logic st, input logic v, input logic [35:0] d, input int ch);
        @(negedge clk);
        bus.start    = st;
        bus.in_valid = v;
        bus.in_data  = d;
        if (ch >= 0) exp_q.push_back('{ch, d});
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic send_stubs(input logic [0:5][5:0] c);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(c[i]); j++) begin
                cyc(1'b0, 1'b1, rnd36(), i);
            end
        end
    endtask

    task automatic run_event(input logic [0:5][5:0] c, input logic [7:0] bx, input logic [7:0] exp_bx,
                             input logic [2:0] exp_err, input bit do_start, input int n_bad);
        if (do_start) cyc(1'b1, 1'b0, 36'h0, -1);
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, c, -1);
        send_stubs(c);
        for (int b = 0; b < n_bad; b++) begin
            cyc(1'b0, 1'b1, 36'h0_1234_5678, -1);
            check("bad_trailer_err", 64'(bus.err), 64'(3'b010));
            check("bad_trailer_nodone", 64'(bus.done), 64'd0);
        end
        cyc(1'b0, 1'b1, trailer(bx), -1);
        check("done_pulse", 64'(bus.done), 64'd1);
        check("bx_next", 64'(bus.bx_next), 64'(exp_bx));
        check("err_at_done", 64'(bus.err), 64'(exp_err));
        cyc(1'b0, 1'b0, 36'h0, -1);
        check("done_low", 64'(bus.done), 64'd0);
        check("err_cleared", 64'(bus.err), 64'd0);
        check("bx_hold", 64'(bus.bx_next), 64'(exp_bx));
    endtask

    initial begin
        vecs[0] = '{c: {6'd2, 6'd1, 6'd0, 6'd3, 6'd0, 6'd1}, bx: 8'd5,   exp_bx: 8'd6};
        vecs[1] = '{c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, bx: 8'd255, exp_bx: 8'd0};
        vecs[2] = '{c: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4}, bx: 8'd100, exp_bx: 8'd101};
        vecs[3] = '{c: {6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1}, bx: 8'd0,   exp_bx: 8'd1};
        vecs[4] = '{c: {6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1}, bx: 8'd254, exp_bx: 8'd255};

        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 36'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(bus.out_wr_en), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_bx", 64'(bus.bx_next), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Without start the router stays idle whatever arrives
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, {6'd2, 30'd0}, -1);
        cyc(1'b0, 1'b1, rnd36(), -1);
        cyc(1'b0, 1'b0, 36'h0, -1);

        for (int v = 0; v < 5; v++) begin
            run_event(vecs[v].c, vecs[v].bx, vecs[v].exp_bx, 3'b000, 1'b1, 0);
        end

        // Valid toggling inside the stub phase
        cyc(1'b1, 1'b0, 36'h0, -1);
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, {6'd3, 30'd0}, -1);
        cyc(1'b0, 1'b1, rnd36(), 0);
        cyc(1'b0, 1'b0, rnd36(), -1);
        cyc(1'b0, 1'b1, rnd36(), 0);
        cyc(1'b0, 1'b0, rnd36(), -1);
        cyc(1'b0, 1'b1, rnd36(), 0);
        cyc(1'b0, 1'b1, trailer(8'd40), -1);
        check("toggle_done", 64'(bus.done), 64'd1);
        check("toggle_bx", 64'(bus.bx_next), 64'd41);

        // Bad word in the trailer phase, then a good trailer
        run_event({6'd0, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0}, 8'd9, 8'd10, 3'b010, 1'b1, 1);

        // Abort after 2 of 4 stubs; the last accepted stub still strobes
        cyc(1'b1, 1'b0, 36'h0, -1);
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, {6'd4, 30'd0}, -1);
        cyc(1'b0, 1'b1, rnd36(), 0);
        cyc(1'b0, 1'b1, rnd36(), 0);
        cyc(1'b1, 1'b1, rnd36(), -1);
        check("abort_err", 64'(bus.err), 64'(3'b100));
        check("abort_nodone", 64'(bus.done), 64'd0);
        run_event({6'd1, 6'd0, 6'd2, 6'd0, 6'd0, 6'd0}, 8'd20, 8'd21, 3'b100, 1'b0, 0);

        // Asynchronous reset in the middle of the stub phase
        cyc(1'b1, 1'b0, 36'h0, -1);
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, {6'd2, 6'd2, 24'd0}, -1);
        cyc(1'b0, 1'b1, rnd36(), 0);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_wr_en", 64'(bus.out_wr_en), 64'd0);
        check("midrst_data", 64'(bus.out_data), 64'd0);
        check("midrst_bx", 64'(bus.bx_next), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        cyc(1'b0, 1'b1, rnd36(), -1);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0, 1'b1, rnd36(), -1);
        cyc(1'b0, 1'b1, rnd36(), -1);
        cyc(1'b0, 1'b1, HDR, -1);
        cyc(1'b0, 1'b1, {6'd1, 30'd0}, -1);
        cyc(1'b0, 1'b1, rnd36(), -1);
        run_event(vecs[0].c, vecs[0].bx, vecs[0].exp_bx, 3'b000, 1'b1, 0);

        cyc(1'b0, 1'b0, 36'h0, -1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
